write_burst_buffer: RTL and testbench
=====================================

WRITE_BURST_BUFFER -- requirements
Module: write_burst_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, record width in bits.
REQ-002 SHALL have parameter BUNDLE_WIDTH, default 8, records per beat; beat width BW = BUNDLE_WIDTH*DATA_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 64, AXI byte-address width.
REQ-004 SHALL have parameter BURST_LEN, default 16, beats per full burst, power of two, 1..256.
REQ-005 SHALL have parameter CNT_WIDTH, default 32, width of the beat-count input.
REQ-006 SHALL have ports: i_clk in 1 clock; i_rst in 1 asynchronous active-high reset.
REQ-007 SHALL have ports: i_start in 1 job-start pulse; i_base_addr in ADDR_WIDTH job byte address; i_num_beats in CNT_WIDTH job beat count.
REQ-008 SHALL have ports: o_busy out 1 job active; o_done out 1 one-cycle job-complete pulse.
REQ-009 SHALL have ports: i_root_data in BW root-FIFO head beat; i_root_data_vld in 1 root FIFO non-empty; o_root_read out 1 root-FIFO pop.
REQ-010 SHALL have AXI write ports: o_awvalid out 1; i_awready in 1; o_awaddr out ADDR_WIDTH; o_awlen out 8; o_wvalid out 1; i_wready in 1; o_wdata out BW; o_wlast out 1; i_bvalid in 1; o_bready out 1.

Function
REQ-011 SHALL read the first-word-fall-through root FIFO: o_root_read = i_root_data_vld & o_busy & ~buf_full & (accepted < i_num_beats); i_root_data is captured in the cycle o_root_read is high.
REQ-012 SHALL buffer beats in a 2*BURST_LEN-deep FIFO with an occupancy count of width log2(2*BURST_LEN)+1.
REQ-013 SHALL implement FSM IDLE, FILL, ADDR, DATA, RESP, DONE.
REQ-014 IDLE -> FILL on i_start; latch address, beat count; clear accepted, issued, outstanding counters; i_start while not IDLE ignored.
REQ-015 IDLE -> DONE directly when i_start with i_num_beats = 0.
REQ-016 FILL -> ADDR when occupancy >= BURST_LEN, or when occupancy = remaining-unissued beats and remaining > 0; burst length L = min(BURST_LEN, remaining).
REQ-017 ADDR: o_awvalid=1, o_awaddr = current address, o_awlen = L-1, stable until i_awready; then -> DATA, address += L*BW/8.
REQ-018 DATA: o_wvalid=1 with buffer head; beat popped on i_wready; o_wlast=1 on the L-th beat; after last handshake -> RESP if all beats issued, else FILL.
REQ-019 W data is never withheld mid-burst: a burst is issued only when all L beats are buffered.
REQ-020 Reading the root FIFO SHALL continue in every non-IDLE state while buffer not full.
REQ-021 o_bready SHALL be 1 whenever out of reset; outstanding counter +1 on AW handshake, -1 on B handshake, unchanged on simultaneous.
REQ-022 RESP -> DONE when outstanding = 0; DONE asserts o_done for exactly one cycle, -> IDLE.
REQ-023 o_busy = 1 in FILL, ADDR, DATA, RESP.
REQ-024 Address arithmetic is modulo 2^ADDR_WIDTH; no 4 KB boundary splitting (base addresses are burst-aligned by software).

Reset
REQ-025 On i_rst: state IDLE; buffer flushed; all counters 0; o_awvalid, o_wvalid, o_wlast, o_root_read, o_done, o_busy = 0; o_awaddr, o_awlen = 0; o_bready = 0 during reset, 1 after.
REQ-026 Reset mid-job SHALL abandon the job with no further AXI activity; no o_done.

Configuration
REQ-027 With WBB_STALL_CNT_EN defined SHALL add output o_stall_cnt (32 bits), counting cycles with o_wvalid & ~i_wready, cleared on i_start and reset, saturating at all-ones; without it the port and counter SHALL not exist.

Structure
REQ-028 FSM state enum and beat-width/byte-increment constants SHALL live in the shared package.
REQ-029 Beat buffer SHALL be an instance of the existing qshift_fifo (FIFO_WIDTH=BW, FIFO_DEPTH=2*BURST_LEN).

Verification
REQ-030 i_num_beats=32, root always valid, AXI always ready -> two AW (awlen 15, addrs base, base+1024), 32 W beats, wlast on beats 16 and 32, o_done once after 2nd B.
REQ-031 i_num_beats=20 -> AW awlen 15 then awlen 3 at base+1024; wlast on beat 4 of 2nd burst.
REQ-032 i_awready low 10 cycles, i_wready toggling 50% -> AW fields stable while waiting; no data loss or reorder; WBB_STALL_CNT_EN build reports exact stall count.
REQ-033 i_num_beats=0 -> o_done pulse 2 cycles after i_start, no AXI traffic, no root reads.
REQ-034 B responses delayed until after last W, both B in same window -> o_done only after outstanding reaches 0; simultaneous AW/B handshake leaves count unchanged.
REQ-035 i_rst asserted mid-DATA -> all outputs reset same cycle, next job from i_start runs correctly.

Source files
------------

// File: rtl/write_burst_buffer_pkg.sv
// Shared FSM state type and beat sizing helpers for write_burst_buffer.
package write_burst_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_RESP = 3'd4,
    ST_DONE = 3'd5
  } wbb_state_t;

  localparam int WBB_STALL_CNT_W = 32;
  localparam int WBB_MAX_BURST   = 256;

  function automatic int beat_width(input int data_w, input int bundle);
    return data_w * bundle;
  endfunction

  // Address advance for one beat, in bytes.
  function automatic int beat_bytes(input int data_w, input int bundle);
    return beat_width(data_w, bundle) / 8;
  endfunction

endpackage

// File: rtl/write_burst_buffer_qshift_fifo.sv
// qshift_fifo: shift-register queue with the head always in slot 0, so the
// head beat is a plain register read (first-word-fall-through).
module qshift_fifo #(
  parameter  int FIFO_WIDTH = 512,
  parameter  int FIFO_DEPTH = 32,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [FIFO_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [FIFO_WIDTH-1:0] o_data,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [CW-1:0]         r_count;
  logic                  w_pop;
  logic                  w_push;
  logic [CW-1:0]         w_wr_idx;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_pop    = i_pop & ~o_empty;
  assign w_push   = i_push & (~o_full | w_pop);
  assign w_wr_idx = w_pop ? (r_count - CW'(1)) : r_count;
  assign o_data   = r_mem[0];
  assign o_count  = r_count;

  // Storage carries no reset; only the occupancy count is control state.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_push && (w_wr_idx == CW'(i))) begin
        r_mem[i] <= i_data;
      end else if (w_pop) begin
        r_mem[i] <= r_mem[(i + 1) % FIFO_DEPTH];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/write_burst_buffer.sv
// write_burst_buffer: drains a FWFT root FIFO into full AXI write bursts.
// Optional build macro WBB_STALL_CNT_EN adds the o_stall_cnt W-stall counter.
module write_burst_buffer
  import write_burst_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int BUNDLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 64,
  parameter int BURST_LEN    = 16,
  parameter int CNT_WIDTH    = 32,
  localparam int BW          = beat_width(DATA_WIDTH, BUNDLE_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [CNT_WIDTH-1:0]  i_num_beats,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic [BW-1:0]         i_root_data,
  input  logic                  i_root_data_vld,
  output logic                  o_root_read,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic [7:0]            o_awlen,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic [BW-1:0]         o_wdata,
  output logic                  o_wlast,
  input  logic                  i_bvalid,
  output logic                  o_bready
`ifdef WBB_STALL_CNT_EN
  ,
  output logic [WBB_STALL_CNT_W-1:0] o_stall_cnt
`endif
);

  localparam int FIFO_DEPTH = 2 * BURST_LEN;
  localparam int OCC_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_BYTES = beat_bytes(DATA_WIDTH, BUNDLE_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] BL_C    = CNT_WIDTH'(BURST_LEN);

  wbb_state_t              r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [CNT_WIDTH-1:0]    r_num;
  logic [CNT_WIDTH-1:0]    r_accepted;
  logic [CNT_WIDTH-1:0]    r_issued;
  logic [CNT_WIDTH-1:0]    r_outstanding;
  logic [8:0]              r_len;
  logic [8:0]              r_beat;
  logic                    r_awvalid;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [7:0]              r_awlen;
  logic                    r_wvalid;
  logic                    r_done;
  logic                    r_bready;

  logic [BW-1:0]           w_head;
  logic [OCC_W-1:0]        w_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_busy;
  logic                    w_root_read;
  logic                    w_pop;
  logic [CNT_WIDTH-1:0]    w_occ;
  logic [CNT_WIDTH-1:0]    w_rem;
  logic [8:0]              w_len;
  logic                    w_burst_ready;
  logic                    w_last;
  logic                    w_aw_hs;
  logic                    w_b_hs;
  logic [ADDR_WIDTH-1:0]   w_incr;

  assign w_busy      = (r_state == ST_FILL) || (r_state == ST_ADDR) ||
                       (r_state == ST_DATA) || (r_state == ST_RESP);
  assign w_root_read = i_root_data_vld & w_busy & ~w_full & (r_accepted < r_num);
  assign w_pop       = r_wvalid & i_wready & ~w_empty;
  assign w_occ       = CNT_WIDTH'(w_count);
  assign w_rem       = r_num - r_issued;
  assign w_len       = (w_rem >= BL_C) ? 9'(BURST_LEN) : 9'(w_rem);
  // A burst may start only once every beat of it sits in the buffer.
  assign w_burst_ready = (w_occ >= BL_C) || ((w_occ == w_rem) && (w_rem != '0));
  assign w_last      = (r_beat == (r_len - 9'd1));
  assign w_aw_hs     = r_awvalid & i_awready;
  assign w_b_hs      = i_bvalid & r_bready;
  assign w_incr      = ADDR_WIDTH'(r_len) * ADDR_WIDTH'(BEAT_BYTES);

  qshift_fifo #(
    .FIFO_WIDTH (BW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_beat_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_root_read),
    .i_data  (i_root_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_num         <= '0;
      r_accepted    <= '0;
      r_issued      <= '0;
      r_outstanding <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_awvalid     <= 1'b0;
      r_awaddr      <= '0;
      r_awlen       <= '0;
      r_wvalid      <= 1'b0;
      r_done        <= 1'b0;
      r_bready      <= 1'b0;
    end else begin
      r_bready <= 1'b1;
      r_done   <= 1'b0;
      if (w_root_read) r_accepted <= r_accepted + CNT_ONE;
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
        2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_addr        <= i_base_addr;
            r_num         <= i_num_beats;
            r_accepted    <= '0;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_state       <= (i_num_beats == '0) ? ST_DONE : ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_burst_ready) begin
            r_len     <= w_len;
            r_awaddr  <= r_addr;
            r_awlen   <= 8'(w_len - 9'd1);
            r_awvalid <= 1'b1;
            r_state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (i_awready) begin
            r_awvalid <= 1'b0;
            r_addr    <= r_addr + w_incr;
            r_beat    <= '0;
            r_wvalid  <= 1'b1;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (i_wready) begin
            r_issued <= r_issued + CNT_ONE;
            r_beat   <= r_beat + 9'd1;
            if (w_last) begin
              r_wvalid <= 1'b0;
              r_state  <= ((r_issued + CNT_ONE) == r_num) ? ST_RESP : ST_FILL;
            end
          end
        end
        ST_RESP: begin
          if (r_outstanding == '0) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef WBB_STALL_CNT_EN
  logic [WBB_STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_stall_cnt <= '0;
    end else if (r_wvalid && !i_wready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + WBB_STALL_CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign o_busy      = w_busy;
  assign o_done      = r_done;
  assign o_root_read = w_root_read;
  assign o_awvalid   = r_awvalid;
  assign o_awaddr    = r_awaddr;
  assign o_awlen     = r_awlen;
  assign o_wvalid    = r_wvalid;
  assign o_wdata     = w_head;
  assign o_wlast     = r_wvalid & w_last;
  assign o_bready    = r_bready;

endmodule

// File: tb/tb_write_burst_buffer.sv
// Bench for write_burst_buffer: random beats and AXI back-pressure checked
// against burst splitting computed from the job size and base address.
module tb_write_burst_buffer;

  localparam int DW         = 64;
  localparam int BUN        = 8;
  localparam int AWD        = 64;
  localparam int BL         = 16;
  localparam int CNTW       = 32;
  localparam int BW         = DW * BUN;
  localparam int BEAT_BYTES = BW / 8;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_start;
  logic [AWD-1:0]  i_base_addr;
  logic [CNTW-1:0] i_num_beats;
  logic            o_busy;
  logic            o_done;
  logic [BW-1:0]   i_root_data;
  logic            i_root_data_vld;
  logic            o_root_read;
  logic            o_awvalid;
  logic            i_awready;
  logic [AWD-1:0]  o_awaddr;
  logic [7:0]      o_awlen;
  logic            o_wvalid;
  logic            i_wready;
  logic [BW-1:0]   o_wdata;
  logic            o_wlast;
  logic            i_bvalid;
  logic            o_bready;
`ifdef WBB_STALL_CNT_EN
  logic [31:0]     o_stall_cnt;
`endif

  write_burst_buffer #(
    .DATA_WIDTH   (DW),
    .BUNDLE_WIDTH (BUN),
    .ADDR_WIDTH   (AWD),
    .BURST_LEN    (BL),
    .CNT_WIDTH    (CNTW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_start         (i_start),
    .i_base_addr     (i_base_addr),
    .i_num_beats     (i_num_beats),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .i_root_data     (i_root_data),
    .i_root_data_vld (i_root_data_vld),
    .o_root_read     (o_root_read),
    .o_awvalid       (o_awvalid),
    .i_awready       (i_awready),
    .o_awaddr        (o_awaddr),
    .o_awlen         (o_awlen),
    .o_wvalid        (o_wvalid),
    .i_wready        (i_wready),
    .o_wdata         (o_wdata),
    .o_wlast         (o_wlast),
    .i_bvalid        (i_bvalid),
    .o_bready        (o_bready)
`ifdef WBB_STALL_CNT_EN
    ,
    .o_stall_cnt     (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Stimulus knobs
  int aw_mode, w_mode, root_mode, b_mode, aw_hold;
  bit b_hold;

  // Reference-side state
  logic [BW-1:0]  root_q[$];
  logic [BW-1:0]  exp_data[$];
  logic [AWD-1:0] aw_addr_q[$];
  logic [7:0]     aw_len_q[$];
  logic [BW-1:0]  w_data_q[$];
  bit             w_last_q[$];
  int b_pend, b_cnt, done_cnt, b_at_done, root_pops, stall_model;
  bit aw_wait;
  logic [AWD-1:0] aw_prev_addr;
  logic [7:0]     aw_prev_len;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  always @(posedge i_clk) begin
    #1;
    if (aw_hold > 0 && o_awvalid) aw_hold--;
    i_awready       = (aw_hold > 0) ? 1'b0 : ((aw_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1);
    i_wready        = (w_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    i_root_data_vld = (root_q.size() > 0) && (root_mode == 0 || $urandom_range(0, 1) == 1);
    i_root_data     = (root_q.size() > 0) ? root_q[0] : '0;
    i_bvalid        = (b_pend > 0) && !b_hold && (b_mode == 0 || $urandom_range(0, 1) == 1);
  end

  // Observe handshakes on the falling edge, where both sides are stable.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_root_read) begin
        if (root_q.size() > 0) void'(root_q.pop_front());
        root_pops++;
      end
      if (aw_wait) begin
        check("aw_stable_valid", 64'(o_awvalid), 64'(1));
        check("aw_stable_addr", o_awaddr, aw_prev_addr);
        check("aw_stable_len", 64'(o_awlen), 64'(aw_prev_len));
      end
      aw_wait      = o_awvalid && !i_awready;
      aw_prev_addr = o_awaddr;
      aw_prev_len  = o_awlen;
      if (o_awvalid && i_awready) begin
        aw_addr_q.push_back(o_awaddr);
        aw_len_q.push_back(o_awlen);
        b_pend++;
      end
      if (o_wvalid && i_wready) begin
        w_data_q.push_back(o_wdata);
        w_last_q.push_back(o_wlast);
      end
      if (o_wvalid && !i_wready) stall_model++;
      if (i_bvalid && o_bready) begin
        b_pend--;
        b_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        b_at_done = b_cnt;
      end
    end
  end

  task automatic clear_obs();
    aw_addr_q.delete();
    aw_len_q.delete();
    w_data_q.delete();
    w_last_q.delete();
    b_pend = 0; b_cnt = 0; done_cnt = 0; b_at_done = -1;
    root_pops = 0; stall_model = 0; aw_wait = 1'b0;
  endtask

  task automatic start_job(input int n, input logic [AWD-1:0] base, input bit hold_b);
    logic [BW-1:0] beat;
    @(posedge i_clk); #1;
    root_q.delete();
    exp_data.delete();
    clear_obs();
    b_hold = hold_b;
    for (int i = 0; i < n + 3; i++) begin
      for (int j = 0; j < BW / 32; j++) beat[j*32 +: 32] = $urandom();
      root_q.push_back(beat);
      if (i < n) exp_data.push_back(beat);
    end
    i_base_addr = base;
    i_num_beats = CNTW'(n);
    i_start     = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run_job(input int n, input logic [AWD-1:0] base, input bit hold_b, input bit extra_start);
    int nb, rem, len, waited;
    logic [AWD-1:0] addr;
    start_job(n, base, hold_b);
    @(negedge i_clk);
    check("busy_after_start", 64'(o_busy), 64'(n != 0));
    if (n == 0) begin
      check("zero_done_cycle1", 64'(o_done), 64'(0));
      @(negedge i_clk);
      check("zero_done_cycle2", 64'(o_done), 64'(1));
      @(negedge i_clk);
      check("zero_done_clear", 64'(o_done), 64'(0));
    end
    if (extra_start) begin
      repeat (4) @(posedge i_clk);
      #1;
      i_start = 1'b1; i_num_beats = 3; i_base_addr = 64'hDEAD_0000;
      @(posedge i_clk); #1;
      i_start = 1'b0;
    end
    waited = 0;
    while (done_cnt == 0 && waited < 4000) begin
      @(negedge i_clk);
      waited++;
      if (hold_b && w_data_q.size() >= n) b_hold = 1'b0;
    end
    check("done_timeout", 64'(done_cnt > 0), 64'(1));
    repeat (6) @(negedge i_clk);
    nb = (n + BL - 1) / BL;
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("b_before_done", 64'(b_at_done), 64'(nb));
    check("aw_count", 64'(aw_addr_q.size()), 64'(nb));
    check("w_count", 64'(w_data_q.size()), 64'(n));
    check("root_pops", 64'(root_pops), 64'(n));
    check("busy_end", 64'(o_busy), 64'(0));
    addr = base;
    rem  = n;
    for (int k = 0; k < nb && k < aw_addr_q.size(); k++) begin
      len = (rem > BL) ? BL : rem;
      check($sformatf("aw_addr[%0d]", k), aw_addr_q[k], addr);
      check($sformatf("aw_len[%0d]", k), 64'(aw_len_q[k]), 64'(len - 1));
      addr = addr + 64'(len * BEAT_BYTES);
      rem  = rem - len;
    end
    for (int i = 0; i < n && i < w_data_q.size(); i++) begin
      check_w($sformatf("w_data[%0d]", i), w_data_q[i], exp_data[i]);
      check($sformatf("w_last[%0d]", i), 64'(w_last_q[i]),
            64'(((i % BL) == BL - 1) || (i == n - 1)));
    end
`ifdef WBB_STALL_CNT_EN
    check("stall_cnt", 64'(o_stall_cnt), 64'(stall_model));
`endif
  endtask

  task automatic set_modes(input int awm, input int wm, input int rm, input int bm, input int awh);
    aw_mode = awm; w_mode = wm; root_mode = rm; b_mode = bm; aw_hold = awh;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, n;
    logic [AWD-1:0] base;
    i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_num_beats = '0;
    i_root_data = '0; i_root_data_vld = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
    b_hold = 1'b0;
    set_modes(0, 0, 0, 0, 0);
    clear_obs();
    repeat (3) @(negedge i_clk);
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_awvalid", 64'(o_awvalid), 64'(0));
    check("rst_wvalid", 64'(o_wvalid), 64'(0));
    check("rst_wlast", 64'(o_wlast), 64'(0));
    check("rst_root_read", 64'(o_root_read), 64'(0));
    check("rst_awaddr", o_awaddr, 64'(0));
    check("rst_awlen", 64'(o_awlen), 64'(0));
    check("rst_bready", 64'(o_bready), 64'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    check("bready_after_rst", 64'(o_bready), 64'(1));

    // Two full bursts, everything ready
    run_job(32, 64'h1000_0000, 1'b0, 1'b0);
    // Full burst plus a 4-beat tail
    run_job(20, 64'h0000_2000, 1'b0, 1'b0);
    // Empty job
    run_job(0, 64'h0000_3000, 1'b0, 1'b0);
    // AW held off, W and root throttled
    set_modes(0, 1, 1, 0, 10);
    run_job(40, 64'h0005_0000, 1'b0, 1'b0);
    // B responses held until every W beat has gone
    set_modes(1, 1, 0, 0, 0);
    run_job(35, 64'h0006_0000, 1'b1, 1'b0);
    // Address wraps past the top of the address space
    set_modes(0, 0, 0, 0, 0);
    run_job(32, 64'hFFFF_FFFF_FFFF_FC00, 1'b0, 1'b0);
    // A start pulse mid-job must be ignored
    run_job(17, 64'h0007_0000, 1'b0, 1'b1);

    // Reset in the middle of the data phase
    set_modes(0, 1, 0, 0, 0);
    start_job(40, 64'h0008_0000, 1'b0);
    waited = 0;
    while (!o_wvalid && waited < 500) begin
      @(negedge i_clk);
      waited++;
    end
    check("wvalid_before_reset", 64'(o_wvalid), 64'(1));
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    #1;
    check("midrst_busy", 64'(o_busy), 64'(0));
    check("midrst_awvalid", 64'(o_awvalid), 64'(0));
    check("midrst_wvalid", 64'(o_wvalid), 64'(0));
    check("midrst_wlast", 64'(o_wlast), 64'(0));
    check("midrst_root_read", 64'(o_root_read), 64'(0));
    check("midrst_done", 64'(o_done), 64'(0));
    check("midrst_awaddr", o_awaddr, 64'(0));
    check("midrst_awlen", 64'(o_awlen), 64'(0));
    check("midrst_bready", 64'(o_bready), 64'(0));
    clear_obs();
    set_modes(0, 0, 0, 0, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (20) @(negedge i_clk);
    check("postrst_aw", 64'(aw_addr_q.size()), 64'(0));
    check("postrst_w", 64'(w_data_q.size()), 64'(0));
    check("postrst_root", 64'(root_pops), 64'(0));
    check("postrst_done", 64'(done_cnt), 64'(0));
    run_job(24, 64'h0009_0000, 1'b0, 1'b0);

    // Random jobs under random back-pressure
    for (int r = 0; r < 4; r++) begin
      n    = int'($urandom_range(1, 50));
      base = {$urandom(), $urandom()} & ~64'h3FF;
      set_modes(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0);
      run_job(n, base, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
